// File: rtl/pla_b10_pkg.sv
// Shared widths and the captured x/z entry type for the PLA b10 capture path.
package pla_b10_pkg;

  localparam int X_W = 15;
  localparam int Z_W = 11;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Z_W-1:0] z;
  } entry_t;

  function automatic entry_t make_entry(input logic [X_W-1:0] x, input logic [Z_W-1:0] z);
    entry_t e;
    e.x = x;
    e.z = z;
    return e;
  endfunction

endpackage

// File: rtl/pla_b10_fifo.sv
// Generic registered FIFO: data visible one cycle after push, no bypass.
// Full/empty come from registered occupancy only; push when full and pop when empty are dropped.
module pla_b10_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = pla_b10_pkg::entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full && !rst;
  assign pop_ok  = pop && !empty && !rst;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is exactly the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pla_b10_capture.sv
// Captures PLA b10 x/z vector pairs into a FIFO, counts accepted pairs and flags z00=1.
// Push-to-out_valid latency 1 cycle; in_ready drops when full, independent of out_ready.
module pla_b10_capture
  import pla_b10_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_W-1:0]         in_x,
  input  logic [Z_W-1:0]         in_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [X_W-1:0]         out_x,
  output logic [Z_W-1:0]         out_z,
  output logic [CNT_W-1:0]       count,
  output logic                   z00_err,
  output logic [$clog2(DEPTH):0] level
);

  entry_t head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_x     = head.x;
  assign out_z     = head.z;

  pla_b10_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (make_entry(in_x, in_z)),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // z00 is tied low in the PLA, so any accepted z00=1 indicates a capture fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      z00_err <= 1'b0;
    end else if (push) begin
      if (count != '1) begin
        count <= count + 1'b1;
      end
      if (in_z[0]) begin
        z00_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pla_b10_capture.sv
// Scenario tasks plus a negedge reference model / scoreboard for pla_b10_capture.
module tb_pla_b10_capture;

  localparam int DEPTH = 4;
  localparam int CW    = 5;
  localparam int LW    = 3;
  localparam int CMAX  = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [14:0]   in_x = '0;
  logic [10:0]   in_z = '0;
  logic          in_ready;
  logic          out_valid;
  logic [14:0]   out_x;
  logic [10:0]   out_z;
  logic [CW-1:0] count;
  logic          z00_err;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  logic [25:0] q[$];
  int          mlevel = 0;
  int          mcount = 0;
  logic        merr = 1'b0;

  pla_b10_capture #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_z     (out_z),
    .count     (count),
    .z00_err   (z00_err),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Reference model: decides acceptance from its own occupancy and scores output data.
  always @(negedge clk) begin
    logic        acc;
    logic        pp;
    logic [25:0] exp_e;
    logic [10:0] exp_st;
    if (rst) begin
      q.delete();
      mlevel = 0;
      mcount = 0;
      merr   = 1'b0;
    end else begin
      exp_st = {(mlevel != DEPTH), (mlevel != 0), LW'(mlevel), CW'(mcount), merr};
      checks = checks + 1;
      if ({in_ready, out_valid, level, count, z00_err} !== exp_st) begin
        errors = errors + 1;
        $display("FAIL model_state got rdy=%0b vld=%0b lvl=%0d cnt=%0d err=%0b want %b",
                 in_ready, out_valid, level, count, z00_err, exp_st);
      end
      acc = in_valid && (mlevel != DEPTH);
      pp  = out_ready && (mlevel != 0);
      if (pp) begin
        checks = checks + 1;
        if (q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_underflow got x=%0h z=%0h want nothing", out_x, out_z);
        end else begin
          exp_e = q.pop_front();
          if ({out_x, out_z} !== exp_e) begin
            errors = errors + 1;
            $display("FAIL sb_data got x=%0h z=%0h want x=%0h z=%0h",
                     out_x, out_z, exp_e[25:11], exp_e[10:0]);
          end
        end
      end
      if (acc) begin
        q.push_back({in_x, in_z});
        if (in_z[0]) merr = 1'b1;
        if (mcount != CMAX) mcount = mcount + 1;
      end
      mlevel = mlevel + (acc ? 1 : 0) - (pp ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks = checks + 1;
    if ({out_valid, in_ready, level, count, z00_err} !== {1'b0, 1'b1, 3'd0, 5'd0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL reset_values got vld=%0b rdy=%0b lvl=%0d cnt=%0d err=%0b want 0 1 0 0 0",
               out_valid, in_ready, level, count, z00_err);
    end
    in_valid = 1'b1;
    in_z     = 11'h001;
    tick();
    checks = checks + 1;
    if (level !== 3'd0 || count !== 5'd0 || z00_err !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL push_in_reset got lvl=%0d cnt=%0d err=%0b want 0 0 0", level, count, z00_err);
    end
    in_valid = 1'b0;
    in_z     = '0;
    rst      = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    in_valid  = 1'b1;
    in_x      = 15'h1234;
    in_z      = 11'h2A6;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks = checks + 1;
    if (out_valid !== 1'b1 || out_x !== 15'h1234 || out_z !== 11'h2A6 || count !== 5'd1) begin
      errors = errors + 1;
      $display("FAIL single_out got vld=%0b x=%0h z=%0h cnt=%0d want 1 1234 2a6 1",
               out_valid, out_x, out_z, count);
    end
    tick();
    checks = checks + 1;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL single_drain got lvl=%0d vld=%0b want 0 0", level, out_valid);
    end
  endtask

  task automatic test_fill_full_pop();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_x = 15'($urandom);
      in_z = 11'($urandom) & 11'h7FE;
      tick();
    end
    in_x = 15'h5A5A;
    in_z = 11'h3C4;
    checks = checks + 1;
    if (level !== 3'd4 || in_ready !== 1'b0 || count !== 5'd4) begin
      errors = errors + 1;
      $display("FAIL fill got lvl=%0d rdy=%0b cnt=%0d want 4 0 4", level, in_ready, count);
    end
    tick();
    checks = checks + 1;
    if (level !== 3'd4 || count !== 5'd4) begin
      errors = errors + 1;
      $display("FAIL fifth_rejected got lvl=%0d cnt=%0d want 4 4", level, count);
    end
    out_ready = 1'b1;
    #1;
    checks = checks + 1;
    if (in_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL full_pop_same_cycle got rdy=%0b want 0", in_ready);
    end
    tick();
    checks = checks + 1;
    if (level !== 3'd3 || in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL full_pop_next got lvl=%0d rdy=%0b want 3 1", level, in_ready);
    end
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    checks = checks + 1;
    if (level !== 3'd0 || q.size() != 0 || count !== 5'd5) begin
      errors = errors + 1;
      $display("FAIL wrap_drain got lvl=%0d left=%0d cnt=%0d want 0 0 5", level, q.size(), count);
    end
  endtask

  task automatic test_stream(input int n, input int want_cnt);
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_x = 15'($urandom);
      in_z = 11'($urandom) & 11'h7FE;
      tick();
      checks = checks + 1;
      if (level !== 3'd1) begin
        errors = errors + 1;
        $display("FAIL stream_level cycle %0d got %0d want 1", i, level);
      end
    end
    in_valid = 1'b0;
    tick();
    checks = checks + 1;
    if (count !== CW'(want_cnt) || level !== 3'd0 || q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL stream_end got cnt=%0d lvl=%0d left=%0d want %0d 0 0",
               count, level, q.size(), want_cnt);
    end
  endtask

  task automatic test_err();
    do_reset();
    in_z = 11'h001;
    tick();
    checks = checks + 1;
    if (z00_err !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL err_no_push got %0b want 0", z00_err);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    checks = checks + 1;
    if (z00_err !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL err_set got %0b want 1", z00_err);
    end
    in_z = 11'h002;
    tick();
    in_z = 11'h7FE;
    tick();
    in_valid = 1'b0;
    tick();
    checks = checks + 1;
    if (z00_err !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL err_sticky got %0b want 1", z00_err);
    end
    rst = 1'b1;
    #1;
    checks = checks + 1;
    if (z00_err !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL err_clear got %0b want 0", z00_err);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_midreset();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_x = 15'(16'h100 + i);
      in_z = 11'(2 * i);
      tick();
    end
    in_valid = 1'b0;
    checks = checks + 1;
    if (level !== 3'd3) begin
      errors = errors + 1;
      $display("FAIL mid_pre got lvl=%0d want 3", level);
    end
    rst = 1'b1;
    #1;
    checks = checks + 1;
    if (out_valid !== 1'b0 || level !== 3'd0 || count !== 5'd0 || in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL mid_async got vld=%0b lvl=%0d cnt=%0d rdy=%0b want 0 0 0 1",
               out_valid, level, count, in_ready);
    end
    tick();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_x     = 15'h7ABC;
    in_z     = 11'h154;
    #1;
    checks = checks + 1;
    if (out_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mid_no_bypass got vld=%0b want 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks = checks + 1;
    if (out_valid !== 1'b1 || level !== 3'd1 || count !== 5'd1 || out_x !== 15'h7ABC) begin
      errors = errors + 1;
      $display("FAIL mid_first_push got vld=%0b lvl=%0d cnt=%0d x=%0h want 1 1 1 7abc",
               out_valid, level, count, out_x);
    end
    out_ready = 1'b1;
    tick();
    checks = checks + 1;
    if (level !== 3'd0) begin
      errors = errors + 1;
      $display("FAIL mid_drain got lvl=%0d want 0", level);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_full_pop();
    test_stream(20, 20);
    test_stream(40, CMAX);
    test_err();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
